// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;
    localparam int MDU_WIDTH = 32;
    localparam int CNT_W     = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;
endpackage

// File: rtl/mdu_sign_fix.sv
// Applies operand signs to the unsigned magnitude result of a signed MULT/DIV.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] raw,
    input  mdu_op_e            op,
    input  logic               sign1,
    input  logic               sign2,
    output logic [2*WIDTH-1:0] result
);
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             neg;

    always_comb begin
        neg    = sign1 ^ sign2;
        quo    = raw[WIDTH-1:0];
        rem    = raw[2*WIDTH-1:WIDTH];
        result = raw;
        case (op)
            MDU_MULT: if (neg) result = -raw;
            MDU_DIV: begin
                // Quotient follows the sign difference, remainder follows the dividend.
                if (neg)   quo = -raw[WIDTH-1:0];
                if (sign1) rem = -raw[2*WIDTH-1:WIDTH];
                result = {rem, quo};
            end
            default: result = raw;
        endcase
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring) unit owning HI/LO.
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO honoured
//   CALC  | one shift-add / restoring-subtract step per cycle, WIDTH steps
//   FIX   | apply signs or divide-by-zero result, write HI/LO, pulse done
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    mdu_state_e         state;
    mdu_op_e            op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   in1_q;
    logic [WIDTH-1:0]   op_b;
    logic               s1_q, s2_q;
    logic [2*WIDTH-1:0] acc;

    mdu_op_e            op_in;
    logic               signed_in;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum, div_rs, div_diff;
    logic [2*WIDTH-1:0] acc_next, fixed;
    logic               is_div;

    always_comb begin
        op_in     = mdu_op_e'(op);
        signed_in = (op_in == MDU_MULT) || (op_in == MDU_DIV);
        mag1      = (signed_in && in1[WIDTH-1]) ? -in1 : in1;
        mag2      = (signed_in && in2[WIDTH-1]) ? -in2 : in2;
        is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : '0);
        div_rs    = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_rs - {1'b0, op_b};
        if (!is_div)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_next = {div_rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .raw    (acc),
        .op     (op_q),
        .sign1  (s1_q),
        .sign2  (s2_q),
        .result (fixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= MDU_MULT;
            cnt         <= '0;
            in1_q       <= '0;
            op_b        <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        op_q  <= op_in;
                        cnt   <= CNT_W'(WIDTH - 1);
                        in1_q <= in1;
                        s1_q  <= in1[WIDTH-1];
                        s2_q  <= in2[WIDTH-1];
                        op_b  <= mag2;
                        acc   <= {{WIDTH{1'b0}}, mag1};
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    // A zero divisor gives a fixed result independent of the iterations.
                    if (is_div && op_b == '0) begin
                        hi          <= in1_q;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= fixed[2*WIDTH-1:WIDTH];
                        lo <= fixed[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in1 = '0, in2 = '0, wdata = '0;
    logic        wr_hi = 1'b0, wr_lo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;
    int n_done;
    logic early_idle;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents start for exactly one rising edge (E0).
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges after E0 until done is seen, with a budget.
    task automatic wait_done(output int cycles, output logic went_idle);
        cycles = 0;
        went_idle = 1'b0;
        while (!done && cycles < 50) begin
            if (!busy) went_idle = 1'b1;
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        #12;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI / MTLO in IDLE
        wr_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi", hi, 32'h1234);
        chk("mthi_lo_untouched", lo, 0);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h55;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mt_both_hi", hi, 32'h55);
        chk("mt_both_lo", lo, 32'h55);

        // Reset in the middle of CALC
        launch(2'b01, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_lo_hold", lo, 0);

        launch(2'b01, 32'd5, 32'd6);
        wait_done(cyc, early_idle);
        chk("post_abort_lo", lo, 30);
        chk("post_abort_hi", hi, 0);

        // MULTU max*max, latency and busy window
        @(negedge clk);
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("max_busy_e0", busy, 1);
        wait_done(cyc, early_idle);
        chk("max_latency", cyc, 33);
        chk("max_busy_held", early_idle, 0);
        chk("max_busy_done", busy, 0);
        chk("max_hi", hi, 32'hFFFF_FFFE);
        chk("max_lo", lo, 32'h0000_0001);
        @(negedge clk);
        chk("done_pulse", done, 0);

        // Signed multiply and divide
        launch(2'b00, -32'sd7, 32'd3);
        wait_done(cyc, early_idle);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFEB);
        @(negedge clk);
        launch(2'b10, -32'sd7, 32'd2);
        wait_done(cyc, early_idle);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        @(negedge clk);
        launch(2'b10, 32'd100, -32'sd7);
        wait_done(cyc, early_idle);
        chk("div_negdiv_lo", lo, 32'hFFFF_FFF2);
        chk("div_negdiv_hi", hi, 32'd2);

        // Overflow and divide by zero
        @(negedge clk);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, early_idle);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 0);
        chk("div_ovf_dbz", div_by_zero, 0);
        @(negedge clk);
        launch(2'b11, 32'd100, 32'd0);
        wait_done(cyc, early_idle);
        chk("dbz_latency", cyc, 33);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_hi", hi, 32'd100);
        chk("dbz_flag", div_by_zero, 1);
        @(negedge clk);
        launch(2'b00, 32'd0, 32'd5);
        wait_done(cyc, early_idle);
        chk("mul0_hi", hi, 0);
        chk("mul0_lo", lo, 0);
        chk("dbz_sticky", div_by_zero, 1);

        // start during busy ignored, operands latched
        @(negedge clk);
        launch(2'b01, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b11; in1 = 32'd7; in2 = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, early_idle);
        chk("ign_latency", cyc, 28);
        chk("ign_lo", lo, 6);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("ign_single_done", n_done, 0);

        // Back-to-back: start in the done cycle
        launch(2'b01, 32'd4, 32'd5);
        wait_done(cyc, early_idle);
        chk("b2b_first", lo, 20);
        launch(2'b01, 32'd7, 32'd8);
        wait_done(cyc, early_idle);
        chk("b2b_latency", cyc, 33);
        chk("b2b_second", lo, 56);

        // MTHI with accepted start, MTLO during busy
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'h77;
        launch(2'b01, 32'd3, 32'd3);
        wr_hi = 1'b0;
        chk("wr_with_start", hi, 32'h77);
        repeat (3) @(negedge clk);
        wr_lo = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mtlo_busy_dropped", lo, 56);
        wait_done(cyc, early_idle);
        chk("mtlo_busy_lo", lo, 9);
        chk("wr_with_start_ovr", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
